alu_exec_ctrl: RTL and testbench

//  Execute-stage controller that sits around alu_8bit: decodes a 3-bit opcode into sel1/sel0/binv/cin/less,

---
 rtl/alu_exec_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execute-stage controller wrapped around an external
// combinational ALU. It latches an opcode and two operands, drives one ALU pass
// (two for SLT), captures the result and flags, and holds them for downstream.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. A source raises valid without looking at
// ready and keeps its payload stable until the transfer edge. Here in_ready is
// high in IDLE, and in DONE when out_ready is high, so a new op can be accepted
// in the same cycle that the previous result is consumed.
module alu_exec_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             cout,
    output logic             err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic             alu_binv,
    output logic             alu_sel1,
    output logic             alu_sel0,
    output logic [WIDTH-1:0] alu_less,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_co,
    output logic [1:0]       dbg_state
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_SLT2 = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;
    logic             r_cout;
    logic             r_err;
    logic             r_set;

    logic             w_accept;
    logic             w_legal;
    logic             w_is_slt;
    logic             w_is_addsub;
    logic             w_binv_op;
    logic             w_sel1_op;
    logic             w_sel0_op;
    logic [WIDTH-1:0] w_beff;
    logic             w_raw_ovf;

    assign w_accept = in_valid & in_ready;

    // Decode the latched opcode into legality, class and first-pass ALU controls.
    always_comb begin
        w_legal     = 1'b0;
        w_is_slt    = 1'b0;
        w_is_addsub = 1'b0;
        w_binv_op   = 1'b0;
        w_sel1_op   = 1'b0;
        w_sel0_op   = 1'b0;
        case (r_op)
            OP_AND: begin
                w_legal = 1'b1;
            end
            OP_OR: begin
                w_legal   = 1'b1;
                w_sel0_op = 1'b1;
            end
            OP_ADD: begin
                w_legal     = 1'b1;
                w_is_addsub = 1'b1;
                w_sel1_op   = 1'b1;
            end
            OP_SUB: begin
                w_legal     = 1'b1;
                w_is_addsub = 1'b1;
                w_binv_op   = 1'b1;
                w_sel1_op   = 1'b1;
            end
            OP_SLT: begin
                w_legal   = 1'b1;
                w_is_slt  = 1'b1;
                w_binv_op = 1'b1;
                w_sel1_op = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // Signed overflow of the first pass: operands agree in sign, sum disagrees.
    assign w_beff    = r_b ^ {WIDTH{w_binv_op}};
    assign w_raw_ovf = (r_a[WIDTH-1] == w_beff[WIDTH-1]) &
                       (alu_result[WIDTH-1] != r_a[WIDTH-1]);

    // State register; reset drops any in-flight op immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: EXEC always finishes in one cycle, SLT adds the SLT2 pass.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_legal && w_is_slt) begin
                    w_next_state = ST_SLT2;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            ST_SLT2: begin
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next_state = in_valid ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output decode: handshake signals and ALU drive; ALU inputs are 0 outside passes.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_cin   = 1'b0;
        alu_binv  = 1'b0;
        alu_sel1  = 1'b0;
        alu_sel0  = 1'b0;
        alu_less  = '0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_EXEC: begin
                if (w_legal) begin
                    alu_a    = r_a;
                    alu_b    = r_b;
                    alu_cin  = w_binv_op;
                    alu_binv = w_binv_op;
                    alu_sel1 = w_sel1_op;
                    alu_sel0 = w_sel0_op;
                end
            end
            ST_SLT2: begin
                alu_a    = r_a;
                alu_b    = r_b;
                alu_cin  = 1'b1;
                alu_binv = 1'b1;
                alu_sel1 = 1'b1;
                alu_sel0 = 1'b1;
                alu_less = {{(WIDTH-1){1'b0}}, r_set};
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Operand latch on every accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= 3'b000;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_accept) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
        end
    end

    // Result/flag capture: EXEC records the first pass, SLT2 overwrites the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cout   <= 1'b0;
            r_err    <= 1'b0;
            r_set    <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            if (!w_legal) begin
                r_result <= '0;
                r_zero   <= 1'b1;
                r_ovf    <= 1'b0;
                r_cout   <= 1'b0;
                r_err    <= 1'b1;
                r_set    <= 1'b0;
            end else begin
                r_result <= alu_result;
                r_zero   <= ~|alu_result;
                r_ovf    <= w_is_addsub & w_raw_ovf;
                r_cout   <= alu_co;
                r_err    <= 1'b0;
                r_set    <= w_is_slt & (alu_result[WIDTH-1] ^ w_raw_ovf);
            end
        end else if (r_state == ST_SLT2) begin
            r_result <= alu_result;
            r_zero   <= ~|alu_result;
        end
    end

    assign result    = r_result;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign cout      = r_cout;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl with a behavioural 8-bit ALU on the alu_* ports.
// Expected results come from plain integer arithmetic per opcode.
module tb_alu_exec_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;
  logic         cout;
  logic         err;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_cin;
  logic         alu_binv;
  logic         alu_sel1;
  logic         alu_sel0;
  logic [W-1:0] alu_less;
  logic [W-1:0] alu_result;
  logic         alu_co;
  logic [1:0]   dbg_state;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         o;
    logic         c;
    logic         e;
    int           lat;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;
  int   cyc;
  logic prev_valid;
  logic rand_ready;

  alu_exec_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(in_op), .a(in_a), .b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf), .cout(cout), .err(err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_binv(alu_binv),
    .alu_sel1(alu_sel1), .alu_sel0(alu_sel0), .alu_less(alu_less),
    .alu_result(alu_result), .alu_co(alu_co),
    .dbg_state(dbg_state)
  );

  // Behavioural ALU: b optionally inverted, adder carry-out always reported.
  logic [W-1:0] w_bx;
  logic [W:0]   w_sum;
  assign w_bx  = alu_b ^ {W{alu_binv}};
  assign w_sum = {1'b0, alu_a} + {1'b0, w_bx} + {{W{1'b0}}, alu_cin};
  assign alu_result = ({alu_sel1, alu_sel0} == 2'b00) ? (alu_a & w_bx) :
                      ({alu_sel1, alu_sel0} == 2'b01) ? (alu_a | w_bx) :
                      ({alu_sel1, alu_sel0} == 2'b10) ? w_sum[W-1:0] : alu_less;
  assign alu_co = w_sum[W];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [2:0] f_op, input logic [W-1:0] fa,
                                 input logic [W-1:0] fb);
    exp_t m;
    int   sa, sb, ua, ub, s;
    sa = int'($signed(fa));
    sb = int'($signed(fb));
    ua = int'(fa);
    ub = int'(fb);
    m.res = '0; m.o = 1'b0; m.c = 1'b0; m.e = 1'b0; m.lat = 2; m.acc = 0;
    case (f_op)
      3'b000: begin m.res = fa & fb; m.c = (ua + ub) > 255; end
      3'b001: begin m.res = fa | fb; m.c = (ua + ub) > 255; end
      3'b010: begin
        s = ua + ub; m.res = 8'(s); m.c = s > 255;
        m.o = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      3'b110: begin
        m.res = 8'(ua - ub); m.c = ua >= ub;
        m.o = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      3'b111: begin
        m.res = (sa < sb) ? 8'd1 : 8'd0; m.c = ua >= ub; m.lat = 3;
      end
      default: begin m.res = '0; m.e = 1'b1; end
    endcase
    m.z = (m.res == '0);
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // scoreboard: compare DONE outputs against the head of the expected queue
  task automatic monitor();
    exp_t e;
    exp_t n;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        cyc++;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("stray_output", 32'(out_valid), 32'd0);
          end else begin
            e = exp_q[0];
            if (!prev_valid) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            chk("result_flags", 32'({result, zero, ovf, cout, err}),
                32'({e.res, e.z, e.o, e.c, e.e}));
            chk("alu_idle_in_done",
                32'({alu_a, alu_b, alu_less, alu_cin, alu_binv, alu_sel1, alu_sel0}), 32'd0);
            chk("in_ready_in_done", 32'(in_ready), 32'(out_ready));
            if (out_ready) void'(exp_q.pop_front());
          end
        end else if (exp_q.size() > 0 && (cyc - exp_q[0].acc) > exp_q[0].lat) begin
          chk("late_output", 32'(out_valid), 32'd1);
          void'(exp_q.pop_front());
        end
        if (in_valid && in_ready) begin
          n = model(in_op, in_a, in_b);
          n.acc = cyc;
          exp_q.push_back(n);
        end
        prev_valid = out_valid;
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int  n;
    bit  done;
    in_valid = 1'b1; in_op = o; in_a = x; in_b = y;
    n = 0; done = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else begin tick(); n++; end
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [W-1:0] r, output logic z, output logic o,
                          output logic c, output logic e);
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    r = '0; z = 1'b0; o = 1'b0; c = 1'b0; e = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1; r = result; z = zero; o = ovf; c = cout; e = err;
      end else n++;
    end
    if (!seen) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] edges [4];
    edges[0] = 8'h00; edges[1] = 8'h7F; edges[2] = 8'h80; edges[3] = 8'hFF;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    logic [W-1:0] r;
    logic z, o, c, e;
    exp_t m;
    int   n;

    tests = 0; fails = 0; cyc = 0; prev_valid = 1'b0; rand_ready = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    fork monitor(); join_none

    // literal pins on the model
    m = model(3'b010, 8'h7F, 8'h01);
    chk("model_add", 32'({m.res, m.z, m.o, m.c, m.e}), 32'({8'h80, 4'b0100}));
    m = model(3'b110, 8'h05, 8'h05);
    chk("model_sub", 32'({m.res, m.z, m.o, m.c, m.e}), 32'({8'h00, 4'b1010}));
    m = model(3'b111, 8'h80, 8'h01);
    chk("model_slt_neg", 32'({m.res, m.o, 8'(m.lat)}), 32'({8'h01, 1'b0, 8'd3}));
    m = model(3'b111, 8'h7F, 8'h80);
    chk("model_slt_ovf", 32'({m.res, m.z, m.o}), 32'({8'h00, 2'b10}));
    m = model(3'b011, 8'hAA, 8'h00);
    chk("model_illegal", 32'({m.res, m.z, m.e}), 32'({8'h00, 2'b11}));

    // reset state
    repeat (3) @(posedge clk);
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outputs", 32'({out_valid, result, zero, ovf, cout, err}), 32'd0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_less, alu_cin, alu_binv, alu_sel1, alu_sel0}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // T1 ADD overflow
    send(3'b010, 8'h7F, 8'h01);
    wait_out(r, z, o, c, e);
    chk("t1_add", 32'({r, z, o, c, e}), 32'({8'h80, 4'b0100}));
    tick();

    // T2 SUB equal operands
    send(3'b110, 8'h05, 8'h05);
    wait_out(r, z, o, c, e);
    chk("t2_sub", 32'({r, z, o, c, e}), 32'({8'h00, 4'b1010}));
    tick();

    // T3 SLT
    send(3'b111, 8'h80, 8'h01);
    wait_out(r, z, o, c, e);
    chk("t3_slt_a", 32'({r, o}), 32'({8'h01, 1'b0}));
    tick();
    send(3'b111, 8'h7F, 8'h80);
    wait_out(r, z, o, c, e);
    chk("t3_slt_b", 32'({r, z, o}), 32'({8'h00, 2'b10}));
    tick();

    // T4 backpressure then same-cycle accept
    out_ready = 1'b0;
    send(3'b110, 8'h30, 8'h10);
    wait_out(r, z, o, c, e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold", 32'({out_valid, result, zero, ovf, cout, err}), 32'({1'b1, 8'h20, 4'b0010}));
      chk("t4_in_ready_low", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'b001, 8'hF0, 8'h0F);
    wait_out(r, z, o, c, e);
    chk("t4_or", 32'({r, z, e}), 32'({8'hFF, 2'b00}));
    tick();

    // T5 reset in SLT2
    send(3'b111, 8'h80, 8'h01);
    @(posedge clk); #1;
    chk("t5_in_slt2", 32'({alu_sel1, alu_sel0}), 32'd3);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_alu", 32'({alu_a, alu_b, alu_less, alu_cin, alu_binv, alu_sel1, alu_sel0}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_output", 32'(out_valid), 32'd0);
    end
    tick();

    // T6 illegal opcode then legal AND
    send(3'b011, 8'hAA, 8'h55);
    wait_out(r, z, o, c, e);
    chk("t6_illegal", 32'({r, z, o, c, e}), 32'({8'h00, 4'b1001}));
    tick();
    send(3'b000, 8'hAA, 8'h0F);
    wait_out(r, z, o, c, e);
    chk("t6_and", 32'({r, z, e}), 32'({8'h0A, 2'b00}));
    tick();

    // randomized stream with random backpressure and gaps
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(3'($urandom_range(0, 7)), pick(), pick());
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) tick();
    end

    // drain
    rand_ready = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
